// File: rtl/autocorr_pkg.sv
// Shared types and helpers for the autocorrelator: lag-agreement metric,
// accumulator width derivation and the history fill state.
package autocorr_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int acc_width(input int frame_words);
    return $clog2(3 * frame_words + 1) + 1;
  endfunction

  // +3 when all three bits match, -3 when none do.
  function automatic logic signed [2:0] agree(input logic [2:0] x, input logic [2:0] y);
    logic [2:0] diff;
    logic [1:0] pc;
    diff = x ^ y;
    pc   = {1'b0, diff[0]} + {1'b0, diff[1]} + {1'b0, diff[2]};
    return signed'(3'd3 - {pc, 1'b0});
  endfunction

endpackage

// File: rtl/autocorrelator_if.sv
// Word input and frame-result output bundle of the autocorrelator.
interface autocorrelator_if #(
  parameter int MAX_LAG = 2,
  parameter int ACC_W   = 6
);
  logic [2:0]               word_in;
  logic                     word_valid;
  logic [MAX_LAG*ACC_W-1:0] corr_out;
  logic                     res_valid;
  logic                     res_ready;
  logic                     overrun;

  modport master (
    output word_in, word_valid, res_ready,
    input  corr_out, res_valid, overrun
  );

  modport slave (
    input  word_in, word_valid, res_ready,
    output corr_out, res_valid, overrun
  );
endinterface

// File: rtl/autocorrelator_lag_history.sv
// Shift buffer of the last MAX_LAG accepted words plus the FILL/RUN tracker
// that tells which lags already have a valid partner word.
module lag_history
  import autocorr_pkg::*;
#(
  parameter int MAX_LAG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         word_i,
  input  logic               valid_i,
  output logic [2:0]         hist_o [MAX_LAG],
  output logic [MAX_LAG-1:0] eligible_o
);

  localparam int CNT_W = $clog2(MAX_LAG + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LAG);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       hist_q [MAX_LAG];
  logic [2:0]       hist_d [MAX_LAG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      for (int i = 0; i < MAX_LAG; i++) hist_q[i] <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL: begin
        if (valid_i) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_MAX) state_d = RUN;
          else                  state_d = FILL;
        end else begin
          state_d = FILL;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    hist_d = hist_q;
    if (valid_i) begin
      hist_d[0] = word_i;
      for (int i = 1; i < MAX_LAG; i++) hist_d[i] = hist_q[i-1];
    end else begin
      hist_d = hist_q;
    end
  end

  // Lag k needs k earlier words in the buffer before it may accumulate.
  always_comb begin
    eligible_o = '0;
    for (int k = 1; k <= MAX_LAG; k++) begin
      eligible_o[k-1] = (state_q == RUN) || (cnt_q >= CNT_W'(k));
    end
  end

  assign hist_o = hist_q;

endmodule

// File: rtl/autocorrelator.sv
// Per-lag bitwise agreement accumulator over fixed frames, with a one-deep
// valid/ready result register that drops (and flags) results under backpressure.
module autocorrelator
  import autocorr_pkg::*;
#(
  parameter int FRAME_WORDS = 8,
  parameter int MAX_LAG     = 2,
  parameter int ACC_W       = acc_width(FRAME_WORDS)
) (
  input logic             clk,
  input logic             rst,
  autocorrelator_if.slave bus
);

  localparam int FC_W = $clog2(FRAME_WORDS);
  localparam logic [FC_W-1:0] LAST = FC_W'(FRAME_WORDS - 1);

  logic [2:0]               hist_s [MAX_LAG];
  logic [MAX_LAG-1:0]       elig_s;
  logic signed [2:0]        agree_s [MAX_LAG];
  logic signed [ACC_W-1:0]  sum_s [MAX_LAG];
  logic signed [ACC_W-1:0]  acc_q [MAX_LAG];
  logic signed [ACC_W-1:0]  acc_d [MAX_LAG];
  logic [FC_W-1:0]          frame_q, frame_d;
  logic [MAX_LAG*ACC_W-1:0] corr_q, corr_d;
  logic                     res_valid_q, res_valid_d;
  logic                     overrun_q, overrun_d;

  lag_history #(.MAX_LAG(MAX_LAG)) u_hist (
    .clk        (clk),
    .rst        (rst),
    .word_i     (bus.word_in),
    .valid_i    (bus.word_valid),
    .hist_o     (hist_s),
    .eligible_o (elig_s)
  );

  // Running sums including the current word; hist_s[k-1] is the word k strobes back.
  always_comb begin
    for (int k = 0; k < MAX_LAG; k++) begin
      agree_s[k] = agree(bus.word_in, hist_s[k]);
      if (elig_s[k]) sum_s[k] = acc_q[k] + $signed({{(ACC_W-3){agree_s[k][2]}}, agree_s[k]});
      else           sum_s[k] = acc_q[k];
    end
  end

  always_comb begin
    acc_d       = acc_q;
    frame_d     = frame_q;
    corr_d      = corr_q;
    res_valid_d = res_valid_q;
    overrun_d   = 1'b0;
    if (res_valid_q && bus.res_ready) res_valid_d = 1'b0;
    else                              res_valid_d = res_valid_q;
    if (bus.word_valid) begin
      if (frame_q == LAST) begin
        frame_d = '0;
        for (int k = 0; k < MAX_LAG; k++) acc_d[k] = '0;
        // A result can load only if the slot is empty or being emptied now.
        if (!res_valid_q || bus.res_ready) begin
          for (int k = 0; k < MAX_LAG; k++) corr_d[k*ACC_W +: ACC_W] = sum_s[k];
          res_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        frame_d = frame_q + FC_W'(1);
        acc_d   = sum_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LAG; k++) acc_q[k] <= '0;
      frame_q     <= '0;
      corr_q      <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      frame_q     <= frame_d;
      corr_q      <= corr_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.corr_out  = corr_q;
  assign bus.res_valid = res_valid_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_autocorrelator.sv
// Self-checking bench for autocorrelator: directed scenarios plus a random
// run, all checked against a word-list reference model.
module tb_autocorrelator;

  localparam int FW = 8;
  localparam int ML = 2;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  autocorrelator_if #(.MAX_LAG(ML), .ACC_W(AW)) bus ();

  autocorrelator #(.FRAME_WORDS(FW), .MAX_LAG(ML), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int mwords[$];
  int macc [ML];
  int mfcnt;
  bit exp_valid;
  bit exp_ovr;
  int exp_corr [ML];

  function automatic int ref_agree(input int x, input int y);
    return 3 - 2 * $countones(x ^ y);
  endfunction

  function automatic int got_lag(input int k);
    logic signed [AW-1:0] v;
    v = bus.corr_out[(k-1)*AW +: AW];
    return int'(v);
  endfunction

  task automatic model_clear();
    mwords.delete();
    mfcnt     = 0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    for (int k = 0; k < ML; k++) begin
      macc[k]     = 0;
      exp_corr[k] = 0;
    end
  endtask

  // Drive one cycle from a negedge and advance the model by the same cycle.
  task automatic step(input bit v, input int w, input bit rdy);
    bit old_valid;
    int n;
    bus.word_valid = v;
    bus.word_in    = 3'(w);
    bus.res_ready  = rdy;
    old_valid = exp_valid;
    exp_ovr   = 1'b0;
    if (old_valid && rdy) exp_valid = 1'b0;
    if (v) begin
      n = mwords.size();
      for (int k = 1; k <= ML; k++)
        if (n >= k) macc[k-1] += ref_agree(w, mwords[n-k]);
      mwords.push_back(w);
      mfcnt++;
      if (mfcnt == FW) begin
        mfcnt = 0;
        if (!old_valid || rdy) begin
          exp_valid = 1'b1;
          for (int k = 0; k < ML; k++) exp_corr[k] = macc[k];
        end else begin
          exp_ovr = 1'b1;
        end
        for (int k = 0; k < ML; k++) macc[k] = 0;
      end
    end
    @(negedge clk);
    bus.word_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_in    = 3'd0;
    bus.res_ready  = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total += 3;
    if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.res_valid); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", bus.overrun); end
    if (bus.corr_out !== '0) begin bad++; $display("FAIL reset_corr got=%0h exp=0", bus.corr_out); end
  endtask

  task automatic test_constant();
    int pulses;
    int res[$];
    pulses = 0;
    do_reset();
    for (int i = 0; i < 2 * FW; i++) begin
      step(1'b1, 7, 1'b1);
      total += 2;
      if (bus.res_valid !== exp_valid) begin bad++; $display("FAIL const_valid step=%0d got=%0b exp=%0b", i, bus.res_valid, exp_valid); end
      if (bus.overrun !== exp_ovr) begin bad++; $display("FAIL const_ovr step=%0d got=%0b exp=%0b", i, bus.overrun, exp_ovr); end
      if (bus.res_valid === 1'b1) begin
        pulses++;
        res.push_back(got_lag(1));
        res.push_back(got_lag(2));
      end
    end
    total += 1;
    if (pulses !== 2) begin bad++; $display("FAIL const_pulses got=%0d exp=2", pulses); end
    if (res.size() == 4) begin
      total += 4;
      if (res[0] !== 21) begin bad++; $display("FAIL const_f1_lag1 got=%0d exp=21", res[0]); end
      if (res[1] !== 18) begin bad++; $display("FAIL const_f1_lag2 got=%0d exp=18", res[1]); end
      if (res[2] !== 24) begin bad++; $display("FAIL const_f2_lag1 got=%0d exp=24", res[2]); end
      if (res[3] !== 24) begin bad++; $display("FAIL const_f2_lag2 got=%0d exp=24", res[3]); end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < 2 * FW; i++) begin
      step(1'b1, (i % 2 == 0) ? 7 : 0, 1'b1);
      if (i == FW - 1 || i == 2 * FW - 1) begin
        total += 3;
        if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL alt_valid step=%0d got=%0b exp=1", i, bus.res_valid); end
        if (got_lag(1) !== ((i == FW - 1) ? -21 : -24)) begin bad++; $display("FAIL alt_lag1 step=%0d got=%0d exp=%0d", i, got_lag(1), (i == FW - 1) ? -21 : -24); end
        if (got_lag(2) !== ((i == FW - 1) ? 18 : 24)) begin bad++; $display("FAIL alt_lag2 step=%0d got=%0d exp=%0d", i, got_lag(2), (i == FW - 1) ? 18 : 24); end
      end
    end
  endtask

  task automatic test_backpressure();
    int ovr_cnt;
    ovr_cnt = 0;
    do_reset();
    for (int i = 0; i < 2 * FW; i++) begin
      step(1'b1, 7, 1'b0);
      if (bus.overrun === 1'b1) ovr_cnt++;
    end
    total += 5;
    if (ovr_cnt !== 1) begin bad++; $display("FAIL bp_ovr_count got=%0d exp=1", ovr_cnt); end
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL bp_ovr_at_end got=%0b exp=1", bus.overrun); end
    if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL bp_held_valid got=%0b exp=1", bus.res_valid); end
    if (got_lag(1) !== 21) begin bad++; $display("FAIL bp_held_lag1 got=%0d exp=21", got_lag(1)); end
    if (got_lag(2) !== 18) begin bad++; $display("FAIL bp_held_lag2 got=%0d exp=18", got_lag(2)); end
    step(1'b0, 0, 1'b1);
    total += 2;
    if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%0b exp=0", bus.res_valid); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL bp_ovr_width got=%0b exp=0", bus.overrun); end
  endtask

  task automatic test_back_to_back_accept();
    do_reset();
    for (int i = 0; i < FW; i++) step(1'b1, 7, 1'b0);
    for (int i = 0; i < FW - 1; i++) step(1'b1, 7, 1'b0);
    step(1'b1, 7, 1'b1);
    total += 4;
    if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL simul_valid got=%0b exp=1", bus.res_valid); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL simul_ovr got=%0b exp=0", bus.overrun); end
    if (got_lag(1) !== 24) begin bad++; $display("FAIL simul_lag1 got=%0d exp=24", got_lag(1)); end
    if (got_lag(2) !== 24) begin bad++; $display("FAIL simul_lag2 got=%0d exp=24", got_lag(2)); end
  endtask

  task automatic test_irregular();
    int res[$];
    do_reset();
    for (int i = 0; i < 2 * FW; i++) begin
      step(1'b1, 7, 1'b1);
      if (bus.res_valid === 1'b1) begin res.push_back(got_lag(1)); res.push_back(got_lag(2)); end
      for (int g = 0; g < int'($urandom_range(1, 5)); g++) begin
        step(1'b0, int'($urandom_range(0, 7)), 1'b1);
        if (bus.res_valid === 1'b1) begin res.push_back(got_lag(1)); res.push_back(got_lag(2)); end
      end
    end
    total += 1;
    if (res.size() !== 4) begin
      bad++; $display("FAIL irr_count got=%0d exp=4", res.size());
    end else begin
      total += 4;
      if (res[0] !== 21) begin bad++; $display("FAIL irr_f1_lag1 got=%0d exp=21", res[0]); end
      if (res[1] !== 18) begin bad++; $display("FAIL irr_f1_lag2 got=%0d exp=18", res[1]); end
      if (res[2] !== 24) begin bad++; $display("FAIL irr_f2_lag1 got=%0d exp=24", res[2]); end
      if (res[3] !== 24) begin bad++; $display("FAIL irr_f2_lag2 got=%0d exp=24", res[3]); end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < FW + 5; i++) step(1'b1, 7, 1'b0);
    rst = 1'b1;
    #1;
    total += 3;
    if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b exp=0", bus.res_valid); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL mid_rst_ovr got=%0b exp=0", bus.overrun); end
    if (bus.corr_out !== '0) begin bad++; $display("FAIL mid_rst_corr got=%0h exp=0", bus.corr_out); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FW; i++) step(1'b1, 7, 1'b1);
    total += 3;
    if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL mid_after_valid got=%0b exp=1", bus.res_valid); end
    if (got_lag(1) !== 21) begin bad++; $display("FAIL mid_after_lag1 got=%0d exp=21", got_lag(1)); end
    if (got_lag(2) !== 18) begin bad++; $display("FAIL mid_after_lag2 got=%0d exp=18", got_lag(2)); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      total += 4;
      if (bus.res_valid !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, bus.res_valid, exp_valid); end
      if (bus.overrun !== exp_ovr) begin bad++; $display("FAIL rnd_ovr cyc=%0d got=%0b exp=%0b", i, bus.overrun, exp_ovr); end
      if (got_lag(1) !== exp_corr[0]) begin bad++; $display("FAIL rnd_lag1 cyc=%0d got=%0d exp=%0d", i, got_lag(1), exp_corr[0]); end
      if (got_lag(2) !== exp_corr[1]) begin bad++; $display("FAIL rnd_lag2 cyc=%0d got=%0d exp=%0d", i, got_lag(2), exp_corr[1]); end
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.word_valid = 1'b0;
    bus.word_in    = 3'd0;
    bus.res_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_constant();
    test_alternating();
    test_backpressure();
    test_back_to_back_accept();
    test_irregular();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autocorrelator.md
# autocorrelator

Downstream consumer of the serial-to-parallel shift register in the autocorrelation chain. Takes each 3-bit word and its one-cycle word strobe, keeps a short history of past words, and accumulates per-lag bitwise agreement over fixed-length frames. At the end of each frame it presents one result per lag on a valid/ready output.

## Interface
Parameters:
- FRAME_WORDS, 8: words per accumulation frame; must be at least 2.
- MAX_LAG, 2: number of lags computed, 1..MAX_LAG; must be at least 1 and less than FRAME_WORDS.
- ACC_W, $clog2(3*FRAME_WORDS+1)+1: signed accumulator width (6 at defaults).

Ports:
- clk, input, 1: sole clock; all state is updated on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- word_in, input, 3: parallel word from the shift register.
- word_valid, input, 1: one-cycle strobe qualifying word_in; the shift register's clk_out, treated as a data strobe in the clk domain.
- corr_out, output, MAX_LAG*ACC_W: signed result; lag k occupies bits [(k-1)*ACC_W +: ACC_W].
- res_valid, output, 1: corr_out holds an unconsumed frame result.
- res_ready, input, 1: consumer accepts the result.
- overrun, output, 1: one-cycle pulse when a completed frame result is dropped.

## Operation
- Agreement of two words: a(x,y) = 3 - 2*popcount(x ^ y), range -3..+3.
- History buffer:
  - Holds the last MAX_LAG accepted words; shifts only on word_valid.
  - Persists across frame boundaries.
  - Cleared only by reset.
- FSM, states FILL and RUN:
  - FILL: entered at reset. The hist_cnt counter (0..MAX_LAG) increments on each word.
  - FILL -> RUN: when hist_cnt reaches MAX_LAG.
  - RUN -> FILL: only on reset.
  - Lag k contributes on a word only when hist_cnt >= k at that word, so after reset the first k words add nothing to lag k.
- Accumulate:
  - On word_valid, acc[k] += a(word_in, hist[k-1]) for every eligible k.
  - The frame counter advances 0..FRAME_WORDS-1 and wraps.
- Frame end (word_valid with frame counter at FRAME_WORDS-1):
  - The final sums include this word's contribution.
  - Final sums go to the output register, and res_valid sets.
  - acc[] clears to 0 on the same edge. The next word starts the new frame.
- Output handshake:
  - A result transfers when res_valid && res_ready.
  - res_valid clears on transfer unless a new result loads on the same edge.
- Boundary cases:
  - Frame end with res_valid=1 and res_ready=0: the new result is dropped, corr_out/res_valid are held, and overrun pulses. acc[] still clears.
  - Frame end with res_valid=1 and res_ready=1: the old result transfers, the new result loads, and res_valid stays 1. No overrun.
  - Gaps between strobes: state is held.
  - Back-to-back strobes: accepted, one per cycle.
- Arithmetic: the worst case |sum| is 3*FRAME_WORDS, which fits ACC_W signed; no saturation logic is needed.
- Reset values: corr_out=0, res_valid=0, overrun=0, acc=0, history=0, hist_cnt=0, frame counter=0, state FILL.

## Timing
- Latency: word_valid sampled at edge t updates acc at t. On a frame-ending word, corr_out/res_valid are visible in the cycle after t.
- overrun is high for exactly the cycle after the dropping edge.
- Mid-operation reset: asserting rst discards the partial frame, history and any pending result immediately, without waiting for a clock.
- No combinational path from res_ready or word_in to any output.

## Structure
- Package autocorr_pkg holds:
  - agree() function returning signed [2:0];
  - ACC_W derivation function;
  - state enum {FILL, RUN}.
- Sub-module lag_history (parameter MAX_LAG): word shift buffer plus hist_cnt, exposing hist[] and per-lag eligible[] flags. The accumulator/handshake logic stays in the top.

## Test plan
All scenarios use FRAME_WORDS=8, MAX_LAG=2, res_ready=1 unless stated.
- **Constant 111 stream:** 16 strobes of 3'b111 after reset -> frame 1: lag1=21, lag2=18; frame 2: lag1=24, lag2=24; res_valid pulses once per frame.
- **Alternating stream:** 111/000 alternating, 16 strobes -> frame 2: lag1=-24, lag2=+24.
- **Backpressure:**
  - res_ready=0 across two frame ends -> frame-1 result held, overrun pulses once at the frame-2 end.
  - Then res_ready=1 -> frame-1 values transfer and res_valid drops.
- **Simultaneous accept and load:** res_ready pulsed exactly on the cycle of a new frame end -> res_valid stays 1, corr_out takes the new values, overrun=0.
- **Irregular strobes:** 1-5 idle cycles between strobes of a constant stream -> results identical to the back-to-back case.
- **Mid-frame reset:** rst asserted after 5 words -> all outputs 0 immediately; the next 8 constant-111 words give lag1=21, lag2=18 (FILL re-entered).
